// File: rtl/register_file_pkg.sv
// ============================================================================
// Module  : register_file_pkg
// Brief   : Shared sizing constants and reserved index/tag encodings for the
//           architectural register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package register_file_pkg;
  localparam int DEF_REG_NUM      = 32;
  localparam int DEF_XLEN         = 32;
  localparam int DEF_ROB_ID_WIDTH = 5;
  localparam int IDX_W            = 5;

  localparam logic [IDX_W-1:0]            ZERO_REG  = 5'd0;
  localparam logic [DEF_ROB_ID_WIDTH-1:0] TAG_READY = 5'd0;
endpackage

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module  : register_file
// Brief   : Architectural register file with per-register rename tags.
//           Commit-to-read bypass on both read ports; rollback clears all tags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int REG_NUM      = DEF_REG_NUM,
  parameter int XLEN         = DEF_XLEN,
  parameter int ROB_ID_WIDTH = DEF_ROB_ID_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [IDX_W-1:0]        rs1_from_dispatcher,
  input  logic [IDX_W-1:0]        rs2_from_dispatcher,
  output logic [ROB_ID_WIDTH-1:0] Q1_to_dispatcher,
  output logic [ROB_ID_WIDTH-1:0] Q2_to_dispatcher,
  output logic [XLEN-1:0]         V1_to_dispatcher,
  output logic [XLEN-1:0]         V2_to_dispatcher,
  input  logic                    en_signal_from_dispatcher,
  input  logic [IDX_W-1:0]        rd_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0] rob_id_from_dispatcher,
  input  logic                    commit_flag,
  input  logic [IDX_W-1:0]        rd_from_rob,
  input  logic [ROB_ID_WIDTH-1:0] Q_from_rob,
  input  logic [XLEN-1:0]         V_from_rob,
  input  logic                    rollback_flag
);

  localparam logic [ROB_ID_WIDTH-1:0] TAG_R = ROB_ID_WIDTH'(TAG_READY);

  logic [XLEN-1:0]         v_q [0:REG_NUM-1];
  logic [XLEN-1:0]         v_d [0:REG_NUM-1];
  logic [ROB_ID_WIDTH-1:0] q_q [0:REG_NUM-1];
  logic [ROB_ID_WIDTH-1:0] q_d [0:REG_NUM-1];

  logic commit_live;
  logic rename_live;

  assign commit_live = rdy_in && commit_flag && (rd_from_rob != ZERO_REG);
  assign rename_live = rdy_in && !rollback_flag && en_signal_from_dispatcher &&
                       (rd_from_dispatcher != ZERO_REG);

  // Commit is applied first so a same-cycle rename of the same rd overrides the tag clear.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      v_d[i] = v_q[i];
      q_d[i] = q_q[i];
    end
    if (commit_live) begin
      v_d[rd_from_rob] = V_from_rob;
      if (q_q[rd_from_rob] == Q_from_rob) begin
        q_d[rd_from_rob] = TAG_R;
      end
    end
    if (rdy_in && rollback_flag) begin
      for (int i = 0; i < REG_NUM; i++) begin
        q_d[i] = TAG_R;
      end
    end
    if (rename_live) begin
      q_d[rd_from_dispatcher] = rob_id_from_dispatcher;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        v_q[i] <= '0;
        q_q[i] <= TAG_R;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        v_q[i] <= v_d[i];
        q_q[i] <= q_d[i];
      end
    end
  end

  // A committing value is forwarded; its tag clears only if no younger rename owns the register.
  function automatic logic [ROB_ID_WIDTH+XLEN-1:0] read_port(input logic [IDX_W-1:0] idx);
    logic [ROB_ID_WIDTH-1:0] tag;
    logic [XLEN-1:0]         val;
    tag = TAG_R;
    val = '0;
    if (idx != ZERO_REG) begin
      tag = q_q[idx];
      val = v_q[idx];
      if (commit_flag && (rd_from_rob == idx)) begin
        val = V_from_rob;
        if (q_q[idx] == Q_from_rob) begin
          tag = TAG_R;
        end
      end
    end
    return {tag, val};
  endfunction

  assign {Q1_to_dispatcher, V1_to_dispatcher} = read_port(rs1_from_dispatcher);
  assign {Q2_to_dispatcher, V2_to_dispatcher} = read_port(rs2_from_dispatcher);

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module  : tb_register_file
// Brief   : Directed self-checking bench for register_file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [4:0]  rs1_from_dispatcher;
  logic [4:0]  rs2_from_dispatcher;
  logic [4:0]  Q1_to_dispatcher;
  logic [4:0]  Q2_to_dispatcher;
  logic [31:0] V1_to_dispatcher;
  logic [31:0] V2_to_dispatcher;
  logic        en_signal_from_dispatcher;
  logic [4:0]  rd_from_dispatcher;
  logic [4:0]  rob_id_from_dispatcher;
  logic        commit_flag;
  logic [4:0]  rd_from_rob;
  logic [4:0]  Q_from_rob;
  logic [31:0] V_from_rob;
  logic        rollback_flag;

  int tests_run = 0;
  int tests_failed = 0;

  register_file dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .rs1_from_dispatcher       (rs1_from_dispatcher),
    .rs2_from_dispatcher       (rs2_from_dispatcher),
    .Q1_to_dispatcher          (Q1_to_dispatcher),
    .Q2_to_dispatcher          (Q2_to_dispatcher),
    .V1_to_dispatcher          (V1_to_dispatcher),
    .V2_to_dispatcher          (V2_to_dispatcher),
    .en_signal_from_dispatcher (en_signal_from_dispatcher),
    .rd_from_dispatcher        (rd_from_dispatcher),
    .rob_id_from_dispatcher    (rob_id_from_dispatcher),
    .commit_flag               (commit_flag),
    .rd_from_rob               (rd_from_rob),
    .Q_from_rob                (Q_from_rob),
    .V_from_rob                (V_from_rob),
    .rollback_flag             (rollback_flag)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic quiet();
    en_signal_from_dispatcher = 1'b0;
    commit_flag               = 1'b0;
    rollback_flag             = 1'b0;
    rd_from_dispatcher        = 5'd0;
    rob_id_from_dispatcher    = 5'd0;
    rd_from_rob               = 5'd0;
    Q_from_rob                = 5'd0;
    V_from_rob                = 32'd0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] id);
    en_signal_from_dispatcher = 1'b1;
    rd_from_dispatcher        = rd;
    rob_id_from_dispatcher    = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] q, input logic [31:0] v);
    commit_flag = 1'b1;
    rd_from_rob = rd;
    Q_from_rob  = q;
    V_from_rob  = v;
  endtask

  task automatic read(input logic [4:0] a, input logic [4:0] b);
    rs1_from_dispatcher = a;
    rs2_from_dispatcher = b;
    #1;
  endtask

  initial begin
    quiet();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rs1_from_dispatcher = 5'd0;
    rs2_from_dispatcher = 5'd0;
    tick();
    rst_in = 1'b0;

    // Reset state
    read(5'd5, 5'd0);
    check("rst_q1", 32'(Q1_to_dispatcher), 32'd0);
    check("rst_v1", V1_to_dispatcher, 32'd0);
    check("rst_q2", 32'(Q2_to_dispatcher), 32'd0);
    check("rst_v2", V2_to_dispatcher, 32'd0);

    // Rename x3 -> 4, then matching commit with bypass
    rename(5'd3, 5'd4);
    tick();
    quiet();
    read(5'd3, 5'd0);
    check("ren_q1", 32'(Q1_to_dispatcher), 32'd4);
    commit(5'd3, 5'd4, 32'h55);
    read(5'd3, 5'd3);
    check("byp_q1", 32'(Q1_to_dispatcher), 32'd0);
    check("byp_v1", V1_to_dispatcher, 32'h55);
    check("byp_v2", V2_to_dispatcher, 32'h55);
    tick();
    quiet();
    read(5'd3, 5'd0);
    check("cmt_q3", 32'(Q1_to_dispatcher), 32'd0);
    check("cmt_v3", V1_to_dispatcher, 32'h55);

    // Stale commit: younger rename keeps the tag
    rename(5'd3, 5'd2);
    tick();
    rename(5'd3, 5'd7);
    tick();
    quiet();
    commit(5'd3, 5'd2, 32'h11);
    read(5'd3, 5'd0);
    check("stale_byp_q", 32'(Q1_to_dispatcher), 32'd7);
    check("stale_byp_v", V1_to_dispatcher, 32'h11);
    tick();
    quiet();
    read(5'd3, 5'd0);
    check("stale_q3", 32'(Q1_to_dispatcher), 32'd7);
    check("stale_v3", V1_to_dispatcher, 32'h11);

    // Same-cycle commit and rename of x6: rename wins the tag
    rename(5'd6, 5'd1);
    tick();
    quiet();
    commit(5'd6, 5'd1, 32'hAA);
    rename(5'd6, 5'd9);
    read(5'd0, 5'd6);
    check("same_byp_q2", 32'(Q2_to_dispatcher), 32'd0);
    check("same_byp_v2", V2_to_dispatcher, 32'hAA);
    tick();
    quiet();
    read(5'd0, 5'd6);
    check("same_q6", 32'(Q2_to_dispatcher), 32'd9);
    check("same_v6", V2_to_dispatcher, 32'hAA);

    // Rollback with commit and rename in the same cycle
    rename(5'd1, 5'd3);
    tick();
    rename(5'd2, 5'd8);
    tick();
    rename(5'd10, 5'd12);
    tick();
    quiet();
    read(5'd2, 5'd10);
    check("pre_rb_q2", 32'(Q1_to_dispatcher), 32'd8);
    check("pre_rb_q10", 32'(Q2_to_dispatcher), 32'd12);
    rollback_flag = 1'b1;
    commit(5'd1, 5'd3, 32'h1000);
    rename(5'd4, 5'd5);
    tick();
    quiet();
    read(5'd1, 5'd4);
    check("rb_q1", 32'(Q1_to_dispatcher), 32'd0);
    check("rb_v1", V1_to_dispatcher, 32'h1000);
    check("rb_q4", 32'(Q2_to_dispatcher), 32'd0);
    read(5'd10, 5'd2);
    check("rb_q10", 32'(Q1_to_dispatcher), 32'd0);
    check("rb_q2", 32'(Q2_to_dispatcher), 32'd0);
    read(5'd3, 5'd6);
    check("rb_q3", 32'(Q1_to_dispatcher), 32'd0);
    check("rb_v3", V1_to_dispatcher, 32'h11);
    check("rb_q6", 32'(Q2_to_dispatcher), 32'd0);

    // rdy_in low holds everything
    rename(5'd7, 5'd6);
    tick();
    quiet();
    rdy_in = 1'b0;
    commit(5'd7, 5'd6, 32'h77);
    rename(5'd8, 5'd4);
    rollback_flag = 1'b1;
    tick();
    quiet();
    rdy_in = 1'b1;
    read(5'd7, 5'd8);
    check("hold_q7", 32'(Q1_to_dispatcher), 32'd6);
    check("hold_v7", V1_to_dispatcher, 32'd0);
    check("hold_q8", 32'(Q2_to_dispatcher), 32'd0);

    // x0 is never written or tagged
    rename(5'd0, 5'd5);
    commit(5'd0, 5'd0, 32'hDEAD);
    read(5'd0, 5'd0);
    check("x0_byp_v", V1_to_dispatcher, 32'd0);
    tick();
    quiet();
    read(5'd0, 5'd7);
    check("x0_q", 32'(Q1_to_dispatcher), 32'd0);
    check("x0_v", V1_to_dispatcher, 32'd0);
    check("x7_q_kept", 32'(Q2_to_dispatcher), 32'd6);

    // Reset clears populated state, even with rdy_in low
    rdy_in = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    read(5'd3, 5'd7);
    check("rst2_v3", V1_to_dispatcher, 32'd0);
    check("rst2_q7", 32'(Q2_to_dispatcher), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
